adc_capture_ctrl: RTL and testbench



---
 rtl/adc_capture_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - pre/post-trigger ADC capture sequencer with circular RAM and AXIS frame output
// Optional feature macro: ADC_CAPTURE_TIMEOUT_EN (adds cfg_timeout / sts_forced forced-trigger timeout)
module adc_capture_ctrl #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  axis_aclk,
  input  logic                  axis_areset,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_level,
  input  logic [DEPTH_LOG2-1:0] cfg_pre,
  input  logic [DEPTH_LOG2:0]   cfg_len,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [7:0]            s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [2:0]            sts_state,
  output logic                  sts_triggered,
  output logic                  sts_done
`ifdef ADC_CAPTURE_TIMEOUT_EN
  ,
  input  logic [15:0]           cfg_timeout,
  output logic                  sts_forced
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEN_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] LEN_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_WAIT  = 3'd2,
    S_POST  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic [1:0]            r_mode;
  logic [7:0]            r_level;
  logic [DEPTH_LOG2-1:0] r_pre;
  logic [DEPTH_LOG2:0]   r_len;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic [7:0]            r_prev;
  logic                  r_have_prev;
  logic                  r_tready;
  logic                  r_mvalid;
  logic [7:0]            r_mdata;
  logic                  r_mlast;
  logic                  r_triggered;
  logic                  r_done;
  logic                  r_rvalid;
  logic [7:0]            r_rdata;
  logic [DEPTH_LOG2:0]   r_issued;
  logic [DEPTH_LOG2:0]   r_loaded;
  logic [7:0]            r_mem [0:DEPTH-1];

  logic [DEPTH_LOG2:0]   w_len_clamp;
  logic [DEPTH_LOG2-1:0] w_pre_clamp;
  logic [DEPTH_LOG2:0]   w_post_need;
  logic                  w_s_acc;
  logic                  w_wr_en;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_trig_hit;
  logic                  w_to_hit;
  logic                  w_out_free;
  logic                  w_rd_en;
  logic                  w_load;
  logic                  w_last_hs;

`ifdef ADC_CAPTURE_TIMEOUT_EN
  logic [15:0] r_timeout;
  logic [15:0] r_tcnt;
  logic        r_forced;
  assign w_to_hit   = (r_timeout != 16'd0) && (r_tcnt == r_timeout);
  assign sts_forced = r_forced;
`else
  assign w_to_hit = 1'b0;
`endif

  // Clamp the requested frame length to 1..DEPTH and pre-trigger count to len-1
  always_comb begin
    w_len_clamp = cfg_len;
    if (cfg_len == '0) begin
      w_len_clamp = LEN_ONE;
    end else if (cfg_len > LEN_MAX) begin
      w_len_clamp = LEN_MAX;
    end
    w_pre_clamp = cfg_pre;
    if ({1'b0, cfg_pre} >= w_len_clamp) begin
      w_pre_clamp = DEPTH_LOG2'(w_len_clamp - 1'b1);
    end
  end

  assign w_post_need = r_len - {1'b0, r_pre} - 1'b1;
  assign w_s_acc     = s_axis_tvalid && r_tready;
  assign w_wr_en     = w_s_acc && ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST));

  // Level-crossing detection only counts once a previous sample exists since arm
  assign w_rise = r_have_prev && (r_prev < r_level) && (s_axis_tdata >= r_level);
  assign w_fall = r_have_prev && (r_prev >= r_level) && (s_axis_tdata < r_level);

  // Select the trigger condition for the latched mode; a timed-out wait forces it
  always_comb begin
    w_trig_hit = 1'b0;
    case (r_mode)
      2'd0:    w_trig_hit = 1'b1;
      2'd1:    w_trig_hit = w_rise;
      2'd2:    w_trig_hit = w_fall;
      default: w_trig_hit = w_rise || w_fall;
    endcase
    if (w_to_hit) begin
      w_trig_hit = 1'b1;
    end
  end

  // Drain pipeline: RAM read register doubles as the skid stage behind the output register
  assign w_out_free = !r_mvalid || m_axis_tready;
  assign w_rd_en    = (r_state == S_DRAIN) && (r_issued != r_len) && (!r_rvalid || w_out_free);
  assign w_load     = (r_state == S_DRAIN) && r_rvalid && w_out_free;
  assign w_last_hs  = r_mvalid && m_axis_tready && r_mlast;

  // Capture RAM: write accepted samples, synchronous one-cycle read for drain
  always_ff @(posedge axis_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= s_axis_tdata;
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[r_rptr];
    end
  end

  // Capture sequencer with registered status and stream outputs
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_level     <= 8'd0;
      r_pre       <= '0;
      r_len       <= LEN_ONE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_prev      <= 8'd0;
      r_have_prev <= 1'b0;
      r_tready    <= 1'b0;
      r_mvalid    <= 1'b0;
      r_mdata     <= 8'd0;
      r_mlast     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_issued    <= '0;
      r_loaded    <= '0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
      r_timeout   <= 16'd0;
      r_tcnt      <= 16'd0;
      r_forced    <= 1'b0;
`endif
    end else if (cfg_abort) begin
      // Abort wins over everything, including a simultaneous arm
      r_state     <= S_IDLE;
      r_tready    <= 1'b1;
      r_mvalid    <= 1'b0;
      r_mlast     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
      r_rvalid    <= 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
      r_forced    <= 1'b0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_tready <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cfg_arm) begin
            r_mode      <= cfg_mode;
            r_level     <= cfg_level;
            r_pre       <= w_pre_clamp;
            r_len       <= w_len_clamp;
            r_wptr      <= '0;
            r_cnt       <= '0;
            r_have_prev <= 1'b0;
            r_triggered <= 1'b0;
            r_state     <= (w_pre_clamp == '0) ? S_WAIT : S_PRE;
`ifdef ADC_CAPTURE_TIMEOUT_EN
            r_timeout   <= cfg_timeout;
            r_tcnt      <= 16'd0;
            r_forced    <= 1'b0;
`endif
          end
        end
        S_PRE: begin
          if (w_s_acc) begin
            r_wptr      <= r_wptr + 1'b1;
            r_prev      <= s_axis_tdata;
            r_have_prev <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt + 1'b1 == {1'b0, r_pre}) begin
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
`ifdef ADC_CAPTURE_TIMEOUT_EN
          if (!w_to_hit) begin
            r_tcnt <= r_tcnt + 16'd1;
          end
          if (w_s_acc && w_to_hit) begin
            r_forced <= 1'b1;
          end
`endif
          if (w_s_acc) begin
            r_wptr      <= r_wptr + 1'b1;
            r_prev      <= s_axis_tdata;
            r_have_prev <= 1'b1;
            if (w_trig_hit) begin
              // Frame starts pre samples before the trigger address, wrapping in the RAM
              r_rptr      <= r_wptr - r_pre;
              r_triggered <= 1'b1;
              r_cnt       <= '0;
              r_issued    <= '0;
              r_loaded    <= '0;
              r_rvalid    <= 1'b0;
              if (w_post_need == '0) begin
                r_state  <= S_DRAIN;
                r_tready <= 1'b0;
              end else begin
                r_state <= S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (w_s_acc) begin
            r_wptr      <= r_wptr + 1'b1;
            r_prev      <= s_axis_tdata;
            r_have_prev <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt + 1'b1 == w_post_need) begin
              r_state  <= S_DRAIN;
              r_tready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_tready <= 1'b0;
          if (w_rd_en) begin
            r_rptr   <= r_rptr + 1'b1;
            r_issued <= r_issued + 1'b1;
            r_rvalid <= 1'b1;
          end else if (w_load) begin
            r_rvalid <= 1'b0;
          end
          if (w_load) begin
            r_mvalid <= 1'b1;
            r_mdata  <= r_rdata;
            r_mlast  <= (r_loaded == r_len - 1'b1);
            r_loaded <= r_loaded + 1'b1;
          end else if (r_mvalid && m_axis_tready) begin
            r_mvalid <= 1'b0;
            r_mlast  <= 1'b0;
          end
          if (w_last_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_triggered <= 1'b0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
          r_forced    <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axis_tready = r_tready;
  assign m_axis_tvalid = r_mvalid;
  assign m_axis_tdata  = r_mdata;
  assign m_axis_tlast  = r_mlast;
  assign sts_state     = r_state;
  assign sts_triggered = r_triggered;
  assign sts_done      = r_done;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - randomized self-checking bench for adc_capture_ctrl against a frame-level model
module tb_adc_capture_ctrl;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic           axis_aclk = 1'b0;
  logic           axis_areset;
  logic           cfg_arm;
  logic           cfg_abort;
  logic [1:0]     cfg_mode;
  logic [7:0]     cfg_level;
  logic [DL2-1:0] cfg_pre;
  logic [DL2:0]   cfg_len;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [7:0]     s_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [7:0]     m_axis_tdata;
  logic           m_axis_tlast;
  logic [2:0]     sts_state;
  logic           sts_triggered;
  logic           sts_done;
`ifdef ADC_CAPTURE_TIMEOUT_EN
  logic [15:0]    cfg_timeout;
  logic           sts_forced;
  bit             forced_seen;
`endif

  always #5 axis_aclk = ~axis_aclk;

  adc_capture_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .axis_aclk(axis_aclk), .axis_areset(axis_areset),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_pre(cfg_pre), .cfg_len(cfg_len),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .sts_state(sts_state), .sts_triggered(sts_triggered),
    .sts_done(sts_done)
`ifdef ADC_CAPTURE_TIMEOUT_EN
    , .cfg_timeout(cfg_timeout), .sts_forced(sts_forced)
`endif
  );

  int errors = 0;
  int checks = 0;
  int seq [512];

  int sidx, cyc, first_cyc, last_cyc, done_cnt, done_cyc, drain_wait, vrand, rmode;
  bit prev_stall, prev_l;
  logic [7:0] prev_d;
  logic [2:0] smp_state;
  logic smp_trig, smp_rdy;
  logic [7:0] got_d [$];
  logic got_l [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: which accepted sample triggers, after clamping len/pre
  function automatic void model(input int mode, input int level, input int pre, input int len,
                                output int pre_e, output int len_e, output int k);
    len_e = (len == 0) ? 1 : ((len > DEPTH) ? DEPTH : len);
    pre_e = (pre >= len_e) ? len_e - 1 : pre;
    k = -1;
    for (int i = pre_e; i < 512 && k < 0; i++) begin
      bit rise, fall;
      if (mode == 0) begin
        k = i;
      end else if (i > 0) begin
        rise = (seq[i-1] < level) && (seq[i] >= level);
        fall = (seq[i-1] >= level) && (seq[i] < level);
        if ((mode == 1 && rise) || (mode == 2 && fall) || (mode == 3 && (rise || fall))) k = i;
      end
    end
  endfunction

  // One clock: observe at negedge, drive new inputs 1 time unit after posedge
  task automatic step();
    @(negedge axis_aclk);
    cyc++;
    smp_state = sts_state;
    smp_trig  = sts_triggered;
    smp_rdy   = s_axis_tready;
    if (prev_stall) begin
      chk("stall_valid", m_axis_tvalid, 1);
      chk("stall_data", m_axis_tdata, prev_d);
      chk("stall_last", m_axis_tlast, prev_l);
    end
    if (s_axis_tvalid && s_axis_tready) sidx++;
    if (m_axis_tvalid && m_axis_tready) begin
      got_d.push_back(m_axis_tdata);
      got_l.push_back(m_axis_tlast);
      if (got_d.size() == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (sts_state == 3'd4 && !m_axis_tvalid && got_d.size() == 0) drain_wait++;
    if (sts_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
`ifdef ADC_CAPTURE_TIMEOUT_EN
    if (sts_forced) forced_seen = 1'b1;
`endif
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_d = m_axis_tdata;
    prev_l = m_axis_tlast;
    @(posedge axis_aclk);
    #1;
    s_axis_tvalid = (done_cnt == 0) && ((vrand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1);
    s_axis_tdata  = 8'((sidx < 512) ? seq[sidx] : 0);
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 1) != 0);
      default: m_axis_tready = (cyc % 3 == 0);
    endcase
  endtask

  task automatic arm(input int mode, input int level, input int pre, input int len, input int vr, input int rm);
    sidx = 0; cyc = 0; first_cyc = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0; drain_wait = 0;
    prev_stall = 1'b0;
    got_d.delete();
    got_l.delete();
    vrand = vr;
    rmode = rm;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    forced_seen = 1'b0;
`endif
    cfg_mode = 2'(mode);
    cfg_level = 8'(level);
    cfg_pre = DL2'(pre);
    cfg_len = (DL2+1)'(len);
    s_axis_tvalid = 1'b0;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
  endtask

  task automatic run(input int mode_in, input int level, input int pre, input int len,
                     input int vr, input int rm, input string tag);
    int mode, pre_e, len_e, k, cons, n;
    bit trig_next, trig_done;
    mode = mode_in;
    model(mode, level, pre, len, pre_e, len_e, k);
    if (k < 0 || k + len_e - pre_e > 500) begin
      mode = 0;
      model(mode, level, pre, len, pre_e, len_e, k);
    end
    cons = k + len_e - pre_e;
    trig_next = 1'b0;
    trig_done = 1'b0;
    arm(mode, level, pre, len, vr, rm);
    for (int i = 0; i < 4000; i++) begin
      step();
      if (trig_next) begin
        chk({tag, "_trig_state"}, smp_state, (len_e - pre_e - 1 == 0) ? 4 : 3);
        chk({tag, "_trig_flag"}, smp_trig, 1);
        trig_next = 1'b0;
        trig_done = 1'b1;
      end else if (!trig_done && sidx == k + 1) begin
        trig_next = 1'b1;
      end
      if (done_cnt > 0 && cyc >= done_cyc + 1) break;
    end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_trig_checked"}, trig_done, 1);
    chk({tag, "_beats"}, got_d.size(), len_e);
    n = (got_d.size() < len_e) ? got_d.size() : len_e;
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s_data%0d", tag, j), got_d[j], seq[k - pre_e + j]);
      chk($sformatf("%s_last%0d", tag, j), got_l[j], (j == len_e - 1) ? 1 : 0);
    end
    chk({tag, "_consumed"}, sidx, cons);
    chk({tag, "_done_timing"}, done_cyc, last_cyc + 1);
    chk({tag, "_drain_latency"}, (drain_wait <= 2) ? 1 : 0, 1);
    if (rm == 0) chk({tag, "_throughput"}, last_cyc - first_cyc, len_e - 1);
    chk({tag, "_idle_state"}, smp_state, 0);
    chk({tag, "_idle_ready"}, smp_rdy, 1);
    chk({tag, "_idle_trig"}, smp_trig, 0);
  endtask

  initial begin
    axis_areset = 1'b1;
    cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_mode = 2'd0; cfg_level = 8'd0;
    cfg_pre = '0; cfg_len = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'd0; m_axis_tready = 1'b1;
    vrand = 0; rmode = 0;
`ifdef ADC_CAPTURE_TIMEOUT_EN
    cfg_timeout = 16'd0;
`endif
    repeat (3) @(posedge axis_aclk);
    #1;
    chk("rst_state", sts_state, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_mlast", m_axis_tlast, 0);
    chk("rst_mdata", m_axis_tdata, 0);
    chk("rst_trig", sts_triggered, 0);
    chk("rst_done", sts_done, 0);
    axis_areset = 1'b0;
    @(posedge axis_aclk);
    #1;
    chk("rst_tready_rise", s_axis_tready, 1);

    // Auto mode, pre=0, len=4 ramp from 0x10
    for (int i = 0; i < 512; i++) seq[i] = (16 + i) & 255;
    run(0, 0, 0, 4, 0, 0, "auto");

    // Rising through 0x80 with three pre-trigger samples
    for (int i = 0; i < 512; i++) seq[i] = (112 + i) & 255;
    run(1, 128, 3, 8, 0, 0, "rising");

    // Long sub-level run wraps the 16-entry RAM several times before the crossing
    for (int i = 0; i < 512; i++) seq[i] = (i < 40) ? $urandom_range(0, 127) : ((144 + i - 40) & 255);
    run(1, 128, 5, 16, 1, 0, "wrap");

    // Output backpressure pattern during drain, full-depth frame
    for (int i = 0; i < 512; i++) seq[i] = $urandom_range(0, 255);
    run(0, 0, 4, 16, 1, 2, "bp");

    // Abort in POST drops the partial frame
    for (int i = 0; i < 512; i++) seq[i] = (112 + i) & 255;
    arm(1, 128, 2, 8, 0, 0);
    for (int i = 0; i < 200 && smp_state != 3'd3; i++) step();
    chk("abort_in_post", smp_state, 3);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    chk("abort_state", sts_state, 0);
    chk("abort_trig", sts_triggered, 0);
    chk("abort_mvalid", m_axis_tvalid, 0);
    repeat (20) step();
    chk("abort_no_beats", got_d.size(), 0);

    // Falling re-arm after abort
    for (int i = 0; i < 512; i++) seq[i] = 32;
    seq[0] = 80; seq[1] = 72; seq[2] = 63; seq[3] = 48; seq[4] = 32;
    run(2, 64, 2, 4, 0, 0, "fall");

    // Simultaneous abort and arm leaves the block idle
    cfg_arm = 1'b1;
    cfg_abort = 1'b1;
    step();
    cfg_arm = 1'b0;
    cfg_abort = 1'b0;
    chk("arm_abort_state", sts_state, 0);
    step();
    chk("arm_abort_hold", smp_state, 0);

    // Reset in the middle of a capture
    for (int i = 0; i < 512; i++) seq[i] = i & 255;
    arm(0, 0, 3, 8, 0, 0);
    step();
    axis_areset = 1'b1;
    step();
    chk("midrst_state", sts_state, 0);
    chk("midrst_tready", s_axis_tready, 0);
    chk("midrst_mvalid", m_axis_tvalid, 0);
    axis_areset = 1'b0;
    step();
    chk("midrst_tready_rise", s_axis_tready, 1);

    // Randomized configurations, including len=0, len>DEPTH and pre>=len clamps
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 512; i++) seq[i] = $urandom_range(0, 255);
      run($urandom_range(0, 3), $urandom_range(1, 255), $urandom_range(0, DEPTH - 1),
          $urandom_range(0, 2 * DEPTH - 1), 1, 1, $sformatf("rnd%0d", t));
    end

`ifdef ADC_CAPTURE_TIMEOUT_EN
    // Forced trigger after the wait timeout on a flat input
    for (int i = 0; i < 512; i++) seq[i] = 32;
    cfg_timeout = 16'd100;
    arm(1, 128, 2, 8, 0, 0);
    for (int i = 0; i < 400 && !(done_cnt > 0 && cyc >= done_cyc + 1); i++) step();
    chk("to_done", done_cnt, 1);
    chk("to_forced", forced_seen, 1);
    chk("to_beats", got_d.size(), 8);
    for (int j = 0; j < got_d.size() && j < 8; j++) chk($sformatf("to_data%0d", j), got_d[j], 32);
    chk("to_latency", (sidx >= 100) ? 1 : 0, 1);
    cfg_timeout = 16'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
